// File: rtl/dev_uart_rx.sv
// dev_uart_rx: 8N1 UART receiver (LSB first, idle high), oversampled by an
// external TIC strobe running at OVS x baud. Start and stop bits are sampled
// at mid bit; each completed byte is offered on RX_DATA with RX_VLD/RX_ACK.
//
// Handshake: RX_VLD is a level that rises when a byte completes and stays
// high until a CLK edge with RX_ACK=1; RX_DATA/RX_FERR are stable while
// RX_VLD=1 unless a newer byte completes. RX_ACK while RX_VLD=0 is ignored.
// A byte completing on the same edge as RX_ACK replaces the acknowledged one
// and keeps RX_VLD high; a byte completing while RX_VLD=1 without RX_ACK
// overwrites the pending byte and sets the sticky RX_OVR.
`timescale 1ns/1ps

module dev_uart_rx #(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TIC,
    input  logic       RxD,
    output logic [7:0] RX_DATA,
    output logic       RX_VLD,
    input  logic       RX_ACK,
    output logic       RX_FERR,
    output logic       RX_OVR,
    output logic       RX_BUSY,
    output logic [2:0] dbg_state
);

    // The oversample counter holds (count - 1), so a count running 1..OVS
    // fits in clog2(OVS) bits.
    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          ovs_cnt, ovs_cnt_nxt;
    logic [2:0]             bit_cnt, bit_cnt_nxt;
    logic [7:0]             shreg, shreg_nxt;
    logic                   done;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign RX_BUSY   = (state != S_IDLE);
    assign dbg_state = state;

    // RxD synchroniser, preset to the idle-high line level, runs every CLK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
    end

    // Frame state and counters; reset aborts any frame in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            ovs_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            ovs_cnt <= ovs_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Next-state logic; nothing moves unless TIC is high.
    always_comb begin
        state_nxt   = state;
        ovs_cnt_nxt = ovs_cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        done        = 1'b0;
        if (TIC) begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state_nxt   = S_START;
                        ovs_cnt_nxt = '0;
                    end
                end
                S_START: begin
                    if (ovs_cnt == HALF_M1) begin
                        ovs_cnt_nxt = '0;
                        bit_cnt_nxt = '0;
                        // A line back high at mid start bit was only a glitch.
                        state_nxt   = rxs ? S_IDLE : S_DATA;
                    end else begin
                        ovs_cnt_nxt = ovs_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (ovs_cnt == FULL_M1) begin
                        shreg_nxt   = {rxs, shreg[7:1]};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        ovs_cnt_nxt = '0;
                        if (bit_cnt == 3'd7) state_nxt = S_STOP;
                    end else begin
                        ovs_cnt_nxt = ovs_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (ovs_cnt == FULL_M1) begin
                        done        = 1'b1;
                        ovs_cnt_nxt = '0;
                        bit_cnt_nxt = '0;
                        // A low stop bit means a break: wait for the line to recover.
                        state_nxt   = rxs ? S_IDLE : S_BREAK;
                    end else begin
                        ovs_cnt_nxt = ovs_cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rxs) state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt   = S_IDLE;
                    ovs_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output byte register and handshake; a completing byte wins over RX_ACK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RX_DATA <= 8'h00;
            RX_VLD  <= 1'b0;
            RX_FERR <= 1'b0;
            RX_OVR  <= 1'b0;
        end else if (done) begin
            RX_DATA <= shreg;
            RX_VLD  <= 1'b1;
            RX_FERR <= ~rxs;
            RX_OVR  <= (RX_VLD & ~RX_ACK) | (RX_OVR & ~RX_ACK);
        end else if (RX_ACK && RX_VLD) begin
            RX_VLD  <= 1'b0;
            RX_OVR  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dev_uart_rx.sv
// Bench for dev_uart_rx: a serial driver plays the transmitter, and a
// scoreboard of bytes delivered since the last acknowledge predicts the
// receiver's outputs (newest byte shown, overrun when more than one is held).
`timescale 1ns/1ps

module tb_dev_uart_rx;

    localparam int OVS         = 16;
    localparam int SYNC_STAGES = 2;
    localparam int FRAME_TICS  = 10 * OVS;
    localparam int LATENCY     = OVS / 2 + 9 * OVS;
    localparam int DONE_EDGE   = LATENCY + 1;

    logic       CLK;
    logic       RST;
    logic       TIC;
    logic       RxD;
    logic [7:0] RX_DATA;
    logic       RX_VLD;
    logic       RX_ACK;
    logic       RX_FERR;
    logic       RX_OVR;
    logic       RX_BUSY;
    logic [2:0] dbg_state;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic       exp_ferr;
    int         vld_edge;

    dev_uart_rx #(.OVS(OVS), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .TIC      (TIC),
        .RxD      (RxD),
        .RX_DATA  (RX_DATA),
        .RX_VLD   (RX_VLD),
        .RX_ACK   (RX_ACK),
        .RX_FERR  (RX_FERR),
        .RX_OVR   (RX_OVR),
        .RX_BUSY  (RX_BUSY),
        .dbg_state(dbg_state)
    );

    // Clock and TIC strobe (one CLK in three).
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        TIC = 1'b0;
        forever begin
            repeat (2) @(negedge CLK);
            TIC = 1'b1;
            @(negedge CLK);
            TIC = 1'b0;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for the next TIC edge and step just past it.
    task automatic tic_edge();
        do @(posedge CLK); while (TIC !== 1'b1);
        #1;
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) tic_edge();
    endtask

    task automatic model_done(input logic [7:0] d, input logic ferr, input bit acked);
        if (acked) exp_q.delete();
        exp_q.push_back(d);
        exp_ferr = ferr;
    endtask

    task automatic ack();
        @(negedge CLK);
        RX_ACK = 1'b1;
        @(negedge CLK);
        RX_ACK = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_vld"}, 32'(RX_VLD), 32'(exp_q.size() != 0));
        check({tag, "_ovr"}, 32'(RX_OVR), 32'(exp_q.size() > 1));
        if (exp_q.size() != 0) begin
            check({tag, "_data"}, 32'(RX_DATA), 32'(exp_q[$]));
            check({tag, "_ferr"}, 32'(RX_FERR), 32'(exp_ferr));
        end
    endtask

    // Drive one frame; optionally ack on the completion edge or reset mid-frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit ack_done,
                              input int rst_at);
        logic [9:0] lv;
        logic       prev_vld;
        lv       = {stop, d, 1'b0};
        prev_vld = RX_VLD;
        vld_edge = -1;
        for (int t = 0; t < FRAME_TICS; t++) begin
            RxD = lv[t / OVS];
            if (t == rst_at) begin
                RST = 1'b1;
                #1;
                check("rst_data", 32'(RX_DATA), 32'h00);
                check("rst_vld", 32'(RX_VLD), 32'h0);
                check("rst_ferr", 32'(RX_FERR), 32'h0);
                check("rst_ovr", 32'(RX_OVR), 32'h0);
                check("rst_busy", 32'(RX_BUSY), 32'h0);
                RxD = 1'b1;
                repeat (5) @(posedge CLK);
                #1;
                RST = 1'b0;
                exp_q.delete();
                exp_ferr = 1'b0;
                return;
            end
            if (ack_done && t == DONE_EDGE - 1) begin
                do begin
                    @(negedge CLK);
                    #1;
                end while (TIC !== 1'b1);
                RX_ACK = 1'b1;
                @(posedge CLK);
                #1;
                RX_ACK = 1'b0;
            end else begin
                tic_edge();
            end
            if (vld_edge < 0 && RX_VLD === 1'b1 && prev_vld !== 1'b1) vld_edge = t + 1;
            prev_vld = RX_VLD;
        end
        model_done(d, ~stop, ack_done);
    endtask

    initial begin
        int         busy_tics;
        logic [7:0] d;
        logic       stop;

        RST    = 1'b1;
        RxD    = 1'b1;
        RX_ACK = 1'b0;
        exp_ferr = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_data", 32'(RX_DATA), 32'h00);
        check("reset_vld", 32'(RX_VLD), 32'h0);
        check("reset_ferr", 32'(RX_FERR), 32'h0);
        check("reset_ovr", 32'(RX_OVR), 32'h0);
        check("reset_busy", 32'(RX_BUSY), 32'h0);
        RST = 1'b0;
        idle(4);
        check("idle_busy", 32'(RX_BUSY), 32'h0);

        // Single clean byte.
        send_frame(8'hA3, 1'b1, 1'b0, -1);
        idle(2);
        check_outputs("a3");
        check("a3_busy", 32'(RX_BUSY), 32'h0);
        ack();
        check_outputs("a3_ack");

        // Short low glitch must be rejected at mid start bit.
        busy_tics = 0;
        RxD = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) RxD = 1'b1;
            tic_edge();
            if (RX_BUSY === 1'b1) busy_tics++;
        end
        check("glitch_busy_seen", 32'(busy_tics > 0), 32'h1);
        check("glitch_busy_short", 32'(busy_tics < OVS / 2 + SYNC_STAGES), 32'h1);
        check("glitch_busy_end", 32'(RX_BUSY), 32'h0);
        check_outputs("glitch");

        // Framing error followed by a held-low line, then a clean byte.
        send_frame(8'h55, 1'b0, 1'b0, -1);
        repeat (3 * OVS) tic_edge();
        check_outputs("brk");
        check("brk_busy", 32'(RX_BUSY), 32'h1);
        idle(4);
        check("brk_release_busy", 32'(RX_BUSY), 32'h0);
        check_outputs("brk_hold");
        ack();
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        idle(2);
        check_outputs("brk_0f");
        ack();

        // Back-to-back bytes without acknowledge give an overrun.
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        idle(2);
        check_outputs("b2b");
        ack();
        check_outputs("b2b_ack");

        // Acknowledge on the completion edge: new byte wins, no overrun.
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h33, 1'b1, 1'b1, -1);
        idle(2);
        check_outputs("ack_done");
        ack();

        // Reset during data bit 4, then latency of the next byte.
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        idle(2);
        check_outputs("pre_rst");
        send_frame(8'hC6, 1'b1, 1'b0, 5 * OVS + 5);
        idle(2 * FRAME_TICS / 10);
        check_outputs("post_rst");
        check("post_rst_busy", 32'(RX_BUSY), 32'h0);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        idle(2);
        check_outputs("7e");
        check("7e_latency", 32'(vld_edge - 1), 32'(LATENCY));
        ack();

        // Random frames with occasional framing errors and random acks.
        for (int i = 0; i < 10; i++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, stop, 1'b0, -1);
            idle(stop ? $urandom_range(0, 3) : $urandom_range(1, 3));
            check_outputs("rnd");
            if ($urandom_range(0, 1) == 1) begin
                ack();
                check_outputs("rnd_ack");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dev_uart_rx.md
Name: dev_uart_rx

Overview:
- Asynchronous UART receiver; the counterpart of the team's dev_uart_tx (8N1, LSB first, idle high).
- Oversamples RxD using an external strobe TIC running at OVS x baud, validates the start and stop bits, and presents each received byte with a valid/ack handshake plus error flags.
- Sits between the RxD pad and the tester-module byte consumer. Loopback with dev_uart_tx is the reference check.

Parameters:
- OVS, 16, TIC strobes per bit period; even, 4..64. Counter width is clog2(OVS).
- SYNC_STAGES, 2, flip-flop stages in the RxD synchroniser; minimum 2.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- TIC  in  1  one-CLK strobe at OVS x baud; all sampling and counting advance only when TIC=1
- RxD  in  1  serial input from pad, asynchronous to CLK
- RX_DATA  out  8  last received byte; held stable while RX_VLD=1
- RX_VLD  out  1  byte available; level signal, held until RX_ACK
- RX_ACK  in  1  consumer accepts byte; clears RX_VLD on the next CLK edge
- RX_FERR  out  1  framing error on the byte in RX_DATA (stop bit sampled low); valid while RX_VLD=1
- RX_OVR  out  1  sticky overrun; set when a byte completes while RX_VLD=1; cleared by RX_ACK
- RX_BUSY  out  1  high in every state except IDLE

Behaviour:
Reset values:
- RX_DATA=0x00, RX_VLD=0, RX_FERR=0, RX_OVR=0, RX_BUSY=0.
- Synchroniser flops preset to 1. State=IDLE, counters=0.
- RST asserted mid-frame aborts the frame immediately; no partial byte is ever presented.

Synchroniser:
- RxD passes through SYNC_STAGES flops clocked every CLK, independent of TIC. "rxs" denotes the synchronised output.

States (transitions occur only on CLK edges where TIC=1):
- IDLE: if rxs=0, go to START with ovs_cnt=1; otherwise stay.
- START: ovs_cnt increments on each TIC. When ovs_cnt reaches OVS/2 (mid start bit):
  - rxs=1: false start; go to IDLE with no outputs changed.
  - rxs=0: go to DATA with ovs_cnt=1 and bit_cnt=0.
- DATA: ovs_cnt increments on each TIC. When ovs_cnt reaches OVS (mid of a data bit):
  - Shift in rxs LSB-first: shreg <= {rxs, shreg[7:1]}.
  - bit_cnt++ and ovs_cnt=1.
  - After the 8th bit, go to STOP.
- STOP: ovs_cnt increments on each TIC. When ovs_cnt reaches OVS (mid stop bit), complete the byte in the same edge:
  - RX_DATA<=shreg, RX_VLD<=1, RX_FERR<=~rxs.
  - If RX_VLD was 1 and RX_ACK is not 1 on this edge, RX_OVR<=1.
  - rxs=1: go to IDLE. Stop is evaluated at mid bit so that back-to-back frames tolerate up to ~3% baud mismatch.
  - rxs=0: go to BREAK.
- BREAK: stay until rxs=1 is seen on a TIC, then go to IDLE. No new start is detected while the line is held low.

Latency:
- RX_VLD rises on the TIC edge at mid stop bit. That is (OVS/2 + 9*OVS) TICs after the first TIC that sees rxs low, plus SYNC_STAGES CLKs of synchroniser delay.

Handshake:
- RX_ACK=1 with RX_VLD=1: RX_VLD<=0 and RX_OVR<=0 on the next edge.
- RX_ACK while RX_VLD=0 is ignored.

Simultaneous events:
- Byte completion on the same edge as RX_ACK: the new byte wins. RX_VLD stays 1, RX_DATA and RX_FERR are updated, RX_OVR is not set and is cleared.
- Byte completion while RX_VLD=1 with no RX_ACK: the new byte overwrites RX_DATA and RX_FERR, RX_VLD stays 1, RX_OVR is set.

TIC gating:
- TIC=0 freezes all counters and state.
- RX_ACK handling and the synchroniser run every CLK regardless of TIC.

Test Plan:
- Send 0xA3 from dev_uart_tx in loopback at OVS=16 -> RX_VLD=1, RX_DATA=0xA3, RX_FERR=0, RX_OVR=0. Bits are received LSB-first, i.e. 1,1,0,0,0,1,0,1 after the start bit.
- Drive RxD low for 4 TICs, then high (glitch) -> state returns to IDLE, RX_VLD stays 0, and RX_BUSY pulses high for fewer than OVS/2+SYNC_STAGES cycles.
- Frame 0x55 with the stop bit forced low, then the line held low for 3 bit times -> RX_VLD=1, RX_DATA=0x55, RX_FERR=1. No second byte is received until the line returns high, after which a clean 0x0F is received with RX_FERR=0.
- Send 0x11 then 0x22 back-to-back with no RX_ACK -> RX_DATA=0x22, RX_VLD=1, RX_OVR=1. Then pulse RX_ACK once -> RX_VLD=0 and RX_OVR=0.
- Assert RX_ACK on exactly the completion edge of 0x33 while 0x11 is pending -> RX_DATA=0x33, RX_VLD=1, RX_OVR=0.
- Assert RST during data bit 4 of 0xC6, then release and send 0x7E -> all outputs return to reset values, with no byte presented for the aborted frame. Next: RX_DATA=0x7E with RX_FERR=0, and RX_VLD rises exactly 152 TICs after the first TIC that sees rxs low.
